// File: rtl/iprf_rd_arb.sv
`default_nettype none
// ============================================================================
// Module   : iprf_rd_arb (with package iprf_rd_arb_pkg)
// Purpose  : Arbitrates the two integer PRF read ports among NUM_REQ
//            reservation-station requesters. The grant is combinational in
//            rd0. The read data comes back in rd1, tagged by the registered
//            grant. The winner is chosen round-robin, except that a requester
//            denied STARVE_LIMIT cycles in a row is forced to win.
// Ports    : clk, reset             - core clock, sync active-high reset
//            nuke_rb1               - pipeline flush (.valid only)
//            req_rd0/rdens_rd0/rdaddrs_rd0 - per-requester read requests
//            gnt_rd0                - one-hot-or-zero grant (rd0)
//            rsp_valid_rd1          - owner of rddatas_rd1 (rd1)
//            rddatas_rd1            - PRF data broadcast to requesters
//            prf_rdens_rd0/prf_rdaddrs_rd0 - PRF read port controls
//            prf_rddatas_rd1        - PRF read data
// Revision : 1.0 - initial release
// ============================================================================
package iprf_rd_arb_pkg;
  typedef logic [6:0]  t_prf_id;
  typedef logic [63:0] t_rv_reg_data;
  typedef struct packed {
    logic       valid;
    logic [5:0] rob_idx;
  } t_nuke_pkt;
endpackage

module iprf_rd_arb
  import iprf_rd_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  t_nuke_pkt                        nuke_rb1,
  input  logic [NUM_REQ-1:0]               req_rd0,
  input  logic [NUM_REQ-1:0][1:0]          rdens_rd0,
  input  t_prf_id [NUM_REQ-1:0][1:0]       rdaddrs_rd0,
  output logic [NUM_REQ-1:0]               gnt_rd0,
  output logic [NUM_REQ-1:0]               rsp_valid_rd1,
  output t_rv_reg_data [1:0]               rddatas_rd1,
  output logic [1:0]                       prf_rdens_rd0,
  output t_prf_id [1:0]                    prf_rdaddrs_rd0,
  input  t_rv_reg_data [1:0]               prf_rddatas_rd1
);

  localparam int                IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int                CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [IDX_W-1:0]  LAST_RST   = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]     r_last_gnt;
  logic [NUM_REQ-1:0]   r_gnt_rd1;
  logic [CNT_W-1:0]     r_starve_cnt [NUM_REQ];

  logic                 w_starve_hit;
  logic [IDX_W-1:0]     w_starve_idx;
  logic                 w_rr_hit;
  logic [IDX_W-1:0]     w_rr_idx;
  int                   w_rr_dist;
  int                   w_rr_best;
  logic [IDX_W-1:0]     w_win_idx;
  logic                 w_any;
  logic                 w_unused_nuke;

  // Only the valid bit of the flush packet matters here.
  assign w_unused_nuke = ^nuke_rb1.rob_idx;

  // Starvation override: lowest-index requester sitting at the limit.
  // Round-robin: requester with the smallest distance past last_gnt.
  always_comb begin
    w_starve_hit = 1'b0;
    w_starve_idx = '0;
    w_rr_hit     = 1'b0;
    w_rr_idx     = '0;
    w_rr_dist    = 0;
    w_rr_best    = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_starve_hit && req_rd0[i] && (r_starve_cnt[i] == STARVE_MAX)) begin
        w_starve_hit = 1'b1;
        w_starve_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      // distance 0 means "immediately after last_gnt"
      w_rr_dist = (i + NUM_REQ - 1 - int'(r_last_gnt)) % NUM_REQ;
      if (req_rd0[i] && (w_rr_dist < w_rr_best)) begin
        w_rr_best = w_rr_dist;
        w_rr_hit  = 1'b1;
        w_rr_idx  = IDX_W'(i);
      end
    end
  end

  assign w_win_idx = w_starve_hit ? w_starve_idx : w_rr_idx;
  // Flush and reset both suppress the grant outright.
  assign w_any     = (w_starve_hit | w_rr_hit) & ~nuke_rb1.valid & ~reset;

  always_comb begin
    gnt_rd0         = '0;
    prf_rdens_rd0   = 2'b00;
    prf_rdaddrs_rd0 = rdaddrs_rd0[w_win_idx];
    if (w_any) begin
      gnt_rd0[w_win_idx] = 1'b1;
      prf_rdens_rd0      = rdens_rd0[w_win_idx];
    end
  end

  // A flush in rd1 kills the response that is in flight at that moment.
  assign rsp_valid_rd1 = (reset || nuke_rb1.valid) ? '0 : r_gnt_rd1;
  assign rddatas_rd1   = prf_rddatas_rd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_gnt <= LAST_RST;
      r_gnt_rd1  <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_starve_cnt[i] <= '0;
      end
    end else begin
      r_gnt_rd1 <= gnt_rd0;
      if (|gnt_rd0) begin
        r_last_gnt <= w_win_idx;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (nuke_rb1.valid || !req_rd0[i] || gnt_rd0[i]) begin
          r_starve_cnt[i] <= '0;
        end else if (r_starve_cnt[i] != STARVE_MAX) begin
          r_starve_cnt[i] <= r_starve_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/iprf_rd_arb.md
IPRF_RD_ARB -- requirements
Module: iprf_rd_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2; number of reservation-station requesters sharing the integer PRF read ports.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4; consecutive denied cycles after which a requester is forced to win.
REQ-003 SHALL have port clk  input  1  core clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port nuke_rb1  input  t_nuke_pkt  pipeline flush; only .valid is used.
REQ-006 SHALL have port req_rd0  input  [NUM_REQ-1:0]  requester i wants the PRF read ports this cycle.
REQ-007 SHALL have port rdens_rd0  input  [NUM_REQ-1:0][1:0]  per-requester per-source read enables.
REQ-008 SHALL have port rdaddrs_rd0  input  [NUM_REQ-1:0][1:0] t_prf_id  per-requester per-source physical register ids.
REQ-009 SHALL have port gnt_rd0  output  [NUM_REQ-1:0]  one-hot-or-zero grant, same cycle as request.
REQ-010 SHALL have port rsp_valid_rd1  output  [NUM_REQ-1:0]  read data on rddatas_rd1 belongs to requester i.
REQ-011 SHALL have port rddatas_rd1  output  [1:0] t_rv_reg_data  read data broadcast to all requesters.
REQ-012 SHALL have port prf_rdens_rd0  output  [1:0]  read enables to the PRF.
REQ-013 SHALL have port prf_rdaddrs_rd0  output  [1:0] t_prf_id  read addresses to the PRF.
REQ-014 SHALL have port prf_rddatas_rd1  input  [1:0] t_rv_reg_data  PRF read data, one cycle after address.

Function
REQ-015 SHALL assert at most one gnt_rd0 bit per cycle, and only for a requester with req_rd0 set.
REQ-016 SHALL grant combinationally in rd0; with no requests, gnt_rd0 = 0 and prf_rdens_rd0 = 0.
REQ-017 SHALL select the winner by round-robin: search starts at (last_gnt+1) mod NUM_REQ; last_gnt updates only on a grant.
REQ-018 SHALL override round-robin: a requesting requester whose starve_cnt equals STARVE_LIMIT wins; if several qualify, the lowest index wins.
REQ-019 SHALL keep a starve_cnt per requester, saturating at STARVE_LIMIT: +1 when req set and not granted, cleared when granted or req deasserted.
REQ-020 SHALL drive prf_rdens_rd0/prf_rdaddrs_rd0 from the winner's rdens_rd0/rdaddrs_rd0; addresses are don't-care when the enable is 0.
REQ-021 SHALL treat a granted request with both rdens 0 as a normal grant (updates last_gnt, counters) with prf_rdens_rd0 = 0.
REQ-022 SHALL register the grant vector into a one-cycle pipe stage; rsp_valid_rd1 = registered grant; latency request-to-data is exactly 1 cycle.
REQ-023 SHALL pass prf_rddatas_rd1 to rddatas_rd1 unmodified (combinational).
REQ-024 SHALL, when nuke_rb1.valid is set, force gnt_rd0 = 0 and prf_rdens_rd0 = 0 that cycle, leave last_gnt unchanged, and clear all starve_cnt.
REQ-025 SHALL, when nuke_rb1.valid is set, force rsp_valid_rd1 = 0 that cycle, dropping the in-flight response.
REQ-026 SHALL accept back-to-back grants every cycle with no bubble.
REQ-027 SHALL wrap last_gnt from NUM_REQ-1 to 0.

Reset
REQ-028 SHALL, while reset is high, drive gnt_rd0 = 0, prf_rdens_rd0 = 0, rsp_valid_rd1 = 0.
REQ-029 SHALL, on reset, set last_gnt = NUM_REQ-1 so requester 0 wins the first tie, and clear all starve_cnt and the grant pipe stage.
REQ-030 SHALL, on reset asserted mid-operation, discard any in-flight response: rsp_valid_rd1 = 0 in the cycle after reset deasserts.

Verification
REQ-031 SHALL cover: after reset, req_rd0=2'b11 for 4 cycles -> gnt_rd0 = 01,10,01,10; rsp_valid_rd1 equals the same sequence delayed 1 cycle.
REQ-032 SHALL cover: req_rd0[0] only, rdens=2'b11, addrs 5/9 -> prf_rdens_rd0=11, addrs 5/9 same cycle; next cycle rsp_valid_rd1=01, rddatas_rd1 = PRF data.
REQ-033 SHALL cover: STARVE_LIMIT=2 with a forced pattern where requester 1 loses 2 cycles -> cycle 3 requester 1 wins regardless of the pointer; its counter clears to 0.
REQ-034 SHALL cover: grant in cycle N and nuke_rb1.valid in N+1 -> rsp_valid_rd1=0 in N+1; a request in N+1 is not granted.
REQ-035 SHALL cover: granted request with rdens=2'b00 -> gnt set, prf_rdens_rd0=00, last_gnt advances, rsp_valid next cycle.
REQ-036 SHALL cover: reset asserted the cycle after a grant -> rsp_valid_rd1=0 throughout reset and in the first cycle after it deasserts; the next tie goes to requester 0.
